// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared Gray-pointer FIFO definitions, used by both the write-side and read-side controllers.
package fifo_wr_ctrl_pkg;

  localparam int FIFO_ADDR_WIDTH_DFLT = 4;
  localparam int FIFO_DEPTH_DFLT      = 1 << FIFO_ADDR_WIDTH_DFLT;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // A Gray pointer exactly DEPTH ahead of another differs only in its top two bits.
  function automatic logic [31:0] gray_full_match(input logic [31:0] peer_gray, input int pw);
    return peer_gray ^ (32'h3 << (pw - 2));
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO control bundle: requester/read-domain inputs and controller status outputs.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  i_wr_en;
  logic [ADDR_WIDTH:0]   i_rd_gray;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_waddr;
  logic [ADDR_WIDTH:0]   o_wr_gray;
  logic                  o_full;
  logic                  o_almost_full;
  logic [ADDR_WIDTH:0]   o_wr_count;
  logic                  o_overflow;

  modport master (
    output i_wr_en, i_rd_gray,
    input  o_ram_we, o_ram_waddr, o_wr_gray, o_full, o_almost_full, o_wr_count, o_overflow
  );

  modport slave (
    input  i_wr_en, i_rd_gray,
    output o_ram_we, o_ram_waddr, o_wr_gray, o_full, o_almost_full, o_wr_count, o_overflow
  );
endinterface

// File: rtl/binary2gray.sv
// Binary to reflected-Gray code converter.
module binary2gray #(
  parameter int BIN_WIDTH = 5
) (
  input  logic [BIN_WIDTH-1:0] i_bin,
  output logic [BIN_WIDTH-1:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray2binary.sv
// Reflected-Gray to binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2binary #(
  parameter int BIN_WIDTH = 5
) (
  input  logic [BIN_WIDTH-1:0] i_gray,
  output logic [BIN_WIDTH-1:0] o_bin
);
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < BIN_WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the Gray-pointer async FIFO.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DFLT,
  parameter int AFULL_THR  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fifo_wr_ctrl_if.slave bus
);
  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_THR);

  logic [PW-1:0] rd_s1_q, rd_s1_d;
  logic [PW-1:0] rd_s2_q, rd_s2_d;
  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] wr_count_q, wr_count_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] full_target;
  logic [PW-1:0] occupancy;

  binary2gray #(.BIN_WIDTH(PW)) u_b2g (
    .i_bin  (wr_bin_next),
    .o_gray (wr_gray_next)
  );

  gray2binary #(.BIN_WIDTH(PW)) u_g2b (
    .i_gray (rd_s2_q),
    .o_bin  (rd_bin)
  );

  always_comb begin
    accept      = bus.i_wr_en & ~full_q;
    wr_bin_next = wr_bin_q + PW'(accept);
    full_target = PW'(gray_full_match(32'(rd_s2_q), PW));
    // Flags use the post-write pointer against the current synchronized read pointer,
    // so they may lag a read but never a write.
    occupancy   = wr_bin_next - rd_bin;

    rd_s1_d    = bus.i_rd_gray;
    rd_s2_d    = rd_s1_q;
    wr_bin_d   = wr_bin_next;
    wr_gray_d  = wr_gray_next;
    wr_count_d = occupancy;
    full_d     = (wr_gray_next == full_target);
    afull_d    = (occupancy >= AFULL_LVL);
    ovf_d      = bus.i_wr_en & full_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_s1_q    <= '0;
      rd_s2_q    <= '0;
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      wr_count_q <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_s1_q    <= rd_s1_d;
      rd_s2_q    <= rd_s2_d;
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      wr_count_q <= wr_count_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
    end
  end

  // The strobe is gated by reset so the RAM sees no write while reset is held.
  assign bus.o_ram_we      = bus.i_wr_en & ~full_q & ~i_rst;
  assign bus.o_ram_waddr   = wr_bin_q[ADDR_WIDTH-1:0];
  assign bus.o_wr_gray     = wr_gray_q;
  assign bus.o_full        = full_q;
  assign bus.o_almost_full = afull_q;
  assign bus.o_wr_count    = wr_count_q;
  assign bus.o_overflow    = ovf_q;

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side pointer and flag controller for the team's Gray-pointer asynchronous FIFO. It sits in the write clock domain between the write requester and the dual-port RAM. It accepts write requests, generates the RAM write enable and address, and publishes a registered Gray-coded write pointer to the read domain. It also synchronizes the read domain's Gray pointer to produce full, almost-full, occupancy and overflow status.

## Interface
- ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THR, 2, o_almost_full asserts when free slots <= AFULL_THR; legal range 0..DEPTH-1.

- i_clk  in  1  write-domain clock; all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wr_en  in  1  write request for this cycle.
- i_rd_gray  in  ADDR_WIDTH+1  read pointer, Gray-coded, from the read domain; asynchronous to i_clk.
- o_ram_we  out  1  RAM write strobe = i_wr_en & ~o_full; combinational.
- o_ram_waddr  out  ADDR_WIDTH  RAM write address = low ADDR_WIDTH bits of the binary write pointer.
- o_wr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, for the read domain.
- o_full  out  1  registered full flag.
- o_almost_full  out  1  registered almost-full flag.
- o_wr_count  out  ADDR_WIDTH+1  registered occupancy as seen by the write side, 0..DEPTH.
- o_overflow  out  1  one-cycle registered pulse: the write was rejected because the FIFO was full.

## Operation
- **Read-pointer synchronizer:** i_rd_gray passes through a 2-flop synchronizer (rd_s1, rd_s2), both reset to 0. rd_s2 is Gray-to-binary converted to rd_bin.
- **Write pointer:** binary write pointer wr_bin, reset 0.
  - accept = i_wr_en & ~o_full.
  - On accept: wr_bin <= wr_bin+1, modulo 2**(ADDR_WIDTH+1).
  - wr_bin_next = wr_bin + accept.
- **Gray output:** o_wr_gray <= bin2gray(wr_bin_next). It is always a registered value and changes by exactly one bit per accepted write.
- **Full:** o_full <= (bin2gray(wr_bin_next) == {~rd_s2[MSB:MSB-1], rd_s2[MSB-2:0]}).
- **Occupancy:** o_wr_count <= wr_bin_next - rd_bin, in ADDR_WIDTH+1-bit unsigned arithmetic. The wrap-around difference is correct by construction.
- **Almost-full:** o_almost_full <= (wr_bin_next - rd_bin) >= DEPTH - AFULL_THR.
- **Overflow:** o_overflow <= i_wr_en & o_full.
- **Pointer wrap:** the pointer wraps from 2**(ADDR_WIDTH+1)-1 to 0 with no flag glitch.
- **Simultaneous write and read-pointer change:** flags are computed from the new wr_bin_next and the current rd_s2. Flags are conservative: full/almost-full may lag a read by the synchronizer latency, but can never be late on a write.
- **Reset:** asserting i_rst at any time, including mid-burst, immediately clears all registers. o_ram_we is forced 0 while i_rst is high, because o_full resets to 0 and o_ram_we is gated by i_rst. After release, writes restart at address 0.

## Timing
- **Reset values:** o_wr_gray 0, o_full 0, o_almost_full 0, o_wr_count 0, o_overflow 0, o_ram_waddr 0, o_ram_we 0.
- **Write path:** a write presented in cycle n drives o_ram_we in cycle n, zero latency. The pointer, o_wr_gray, o_wr_count and flags update at edge n+1.
- **Full on write:** the write filling the last slot raises o_full at that same edge. The next cycle's request is rejected.
- **Read release:** a change of i_rd_gray before edge k reaches rd_s2 at edge k+1. o_full, o_almost_full and o_wr_count reflect it after edge k+2.
- **Overflow:** o_overflow is high for the cycle after each rejected request.

## Structure
- **Shared FIFO package/header:**
  - pointer-width rule ADDR_WIDTH+1;
  - DEPTH localparam;
  - the full-compare "invert top two Gray bits" function.
  These are reused by the read-side controller.
- **Sub-modules:**
  - Instantiate the existing binary2gray converter for bin2gray(wr_bin_next).
  - Add one new sub-module, gray2binary (prefix-XOR from MSB, parameter BIN_WIDTH), for rd_s2 -> rd_bin.

## Test plan
All scenarios use ADDR_WIDTH=4 and AFULL_THR=2.
1. **Fill:** release reset, hold i_rd_gray=0, apply 16 consecutive writes.
   - o_ram_waddr steps 0..15.
   - o_almost_full rises after the 14th edge.
   - o_full rises after the 16th edge.
   - o_wr_count=16, o_wr_gray=5'b11000.
2. **Overflow:** while full, hold i_wr_en=1 for 3 cycles.
   - o_ram_we stays 0.
   - o_overflow is high for 3 cycles.
   - o_wr_gray stays 5'b11000.
3. **Release:** while full, drive i_rd_gray=5'b00110 (binary 4).
   - o_full falls exactly 3 edges later.
   - o_wr_count=12, o_almost_full=0.
4. **Wrap:** stream writes while the read pointer trails by 3, across pointer 31->0.
   - o_wr_gray goes 5'b10000 -> 5'b00000.
   - o_full never asserts, o_wr_count stays 3.
5. **Mid-burst reset:** assert i_rst between edges after 7 writes.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the first write uses o_ram_waddr=0.
